// File: rtl/cmd_reader_rmw.sv
// ---------------------------------------------------------------------------
// cmd_reader_rmw
//   In-band command processor on the TX side of the USB/FX2 path.
//   It pops control packets from the TX control FIFO and holds each packet
//   until its timestamp falls due. It then executes the packet's commands in
//   order: PING, WRITE_REG, read-modify-write WRITE_REG_MASKED, READ_REG and
//   DELAY. Replies are streamed as 16-bit words into the RX control path.
//
// Ports
//   txclk, reset       clock and synchronous active-high reset
//   timestamp_clock    free-running sample timestamp
//   pkt_waiting        at least one complete packet sits in the FIFO
//   fifodata           show-ahead FIFO head word
//   rdreq / skip       pop one word / discard the rest of the current packet
//   rx_WR_enabled      RX path can take a word this cycle
//   rx_WR/rx_databus   reply word strobe and data
//   rx_WR_done         one-cycle pulse after the last word of a reply
//   reg_*              register bus: 2 = write, 3 = read, one cycle per access
//                      (reg_data_out is valid the cycle after a read)
//   stop / stop_time   DELAY pulse and its duration (duration held)
//   err_count          saturating count of dropped packets/commands
// ---------------------------------------------------------------------------
module cmd_reader_rmw #(
    parameter int JITTER = 5,
    parameter int ADDR_W = 7,
    parameter int ERR_W  = 8
) (
    input  logic              txclk,
    input  logic              reset,
    input  logic [31:0]       timestamp_clock,
    input  logic              pkt_waiting,
    input  logic [31:0]       fifodata,
    output logic              rdreq,
    output logic              skip,
    input  logic              rx_WR_enabled,
    output logic              rx_WR,
    output logic [15:0]       rx_databus,
    output logic              rx_WR_done,
    input  logic [31:0]       reg_data_out,
    output logic [31:0]       reg_data_in,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [1:0]        reg_io_enable,
    output logic              stop,
    output logic [15:0]       stop_time,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [7:0] OP_PING   = 8'd0;
    localparam logic [7:0] OP_WREG   = 8'd2;
    localparam logic [7:0] OP_WREG_M = 8'd3;
    localparam logic [7:0] OP_RREG   = 8'd4;
    localparam logic [7:0] OP_DELAY  = 8'd12;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_TS, S_WAIT, S_DISPATCH, S_PING, S_WREG,
        S_RMW_RD, S_RMW_WR, S_RREG, S_DELAY, S_SEND
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;       // sub-step inside multi-cycle states
    logic [6:0]         remaining_q, remaining_d;
    logic [31:0]        ts_q, ts_d;
    logic [15:0]        cmd_lo_q, cmd_lo_d;
    logic [31:0]        val_q, val_d;
    logic [31:0]        mask_q, mask_d;
    logic [15:0]        reply_q [4];
    logic [15:0]        reply_d [4];
    logic [2:0]         reply_len_q, reply_len_d;
    logic [1:0]         reply_idx_q, reply_idx_d;
    logic [15:0]        rx_databus_q, rx_databus_d;
    logic [ADDR_W-1:0]  reg_addr_q, reg_addr_d;
    logic [31:0]        reg_data_in_q, reg_data_in_d;
    logic               stop_q, stop_d;
    logic [15:0]        stop_time_q, stop_time_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               err_inc;

    logic [6:0]         need_words;   // 0 marks an unknown opcode
    logic signed [31:0] ts_delta;

    // Modular difference read as signed keeps the compare correct across
    // the 2^32 wrap of timestamp_clock.
    assign ts_delta = ts_q - timestamp_clock;

    always_comb begin
        need_words = 7'd0;
        case (fifodata[31:24])
            OP_PING, OP_RREG, OP_DELAY: need_words = 7'd1;
            OP_WREG:                    need_words = 7'd2;
            OP_WREG_M:                  need_words = 7'd3;
            default:                    need_words = 7'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        remaining_d   = remaining_q;
        ts_d          = ts_q;
        cmd_lo_d      = cmd_lo_q;
        val_d         = val_q;
        mask_d        = mask_q;
        reply_d       = reply_q;
        reply_len_d   = reply_len_q;
        reply_idx_d   = reply_idx_q;
        rx_databus_d  = rx_databus_q;
        reg_addr_d    = reg_addr_q;
        reg_data_in_d = reg_data_in_q;
        stop_d        = 1'b0;
        stop_time_d   = stop_time_q;
        err_inc       = 1'b0;
        rdreq         = 1'b0;
        skip          = 1'b0;
        rx_WR         = 1'b0;
        rx_WR_done    = 1'b0;
        reg_io_enable = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (pkt_waiting) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                rdreq       = 1'b1;
                remaining_d = fifodata[8:2];
                state_d     = S_TS;
            end
            S_TS: begin
                rdreq   = 1'b1;
                ts_d    = fifodata;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if ((ts_q == 32'hFFFF_FFFF) || ((ts_delta > 0) && (ts_delta <= JITTER))) begin
                    state_d = S_DISPATCH;
                end else if (ts_delta <= 0) begin
                    skip    = 1'b1;
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DISPATCH: begin
                // The head word is decoded before popping, so a bad or
                // truncated command is dropped with skip and no rdreq.
                if (remaining_q == 7'd0) begin
                    skip    = 1'b1;
                    state_d = S_IDLE;
                end else if ((need_words == 7'd0) || (remaining_q < need_words)) begin
                    skip    = 1'b1;
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rdreq       = 1'b1;
                    remaining_d = remaining_q - 7'd1;
                    cmd_lo_d    = fifodata[15:0];
                    phase_d     = 2'd0;
                    case (fifodata[31:24])
                        OP_PING:   state_d = S_PING;
                        OP_WREG:   state_d = S_WREG;
                        OP_WREG_M: state_d = S_RMW_RD;
                        OP_RREG:   state_d = S_RREG;
                        OP_DELAY:  state_d = S_DELAY;
                        default:   state_d = S_IDLE;
                    endcase
                    if ((fifodata[31:24] == OP_WREG) || (fifodata[31:24] == OP_WREG_M) ||
                        (fifodata[31:24] == OP_RREG)) begin
                        reg_addr_d = fifodata[ADDR_W-1:0];
                    end
                end
            end
            S_PING: begin
                reply_d[0]   = 16'h0102;
                reply_d[1]   = cmd_lo_q;
                reply_len_d  = 3'd2;
                reply_idx_d  = 2'd0;
                rx_databus_d = 16'h0102;
                phase_d      = 2'd0;
                state_d      = S_SEND;
            end
            S_WREG: begin
                if (phase_q == 2'd0) begin
                    rdreq         = 1'b1;
                    remaining_d   = remaining_q - 7'd1;
                    reg_data_in_d = fifodata;
                    phase_d       = 2'd1;
                end else begin
                    reg_io_enable = 2'd2;
                    state_d       = S_DISPATCH;
                end
            end
            S_RMW_RD: begin
                // phase 0: pop value, phase 1: pop mask, phase 2: read cycle
                if (phase_q == 2'd0) begin
                    rdreq       = 1'b1;
                    remaining_d = remaining_q - 7'd1;
                    val_d       = fifodata;
                    phase_d     = 2'd1;
                end else if (phase_q == 2'd1) begin
                    rdreq       = 1'b1;
                    remaining_d = remaining_q - 7'd1;
                    mask_d      = fifodata;
                    phase_d     = 2'd2;
                end else begin
                    reg_io_enable = 2'd3;
                    phase_d       = 2'd0;
                    state_d       = S_RMW_WR;
                end
            end
            S_RMW_WR: begin
                // phase 0 captures the read data, phase 1 writes it back,
                // so the write lands exactly two cycles after the read.
                if (phase_q == 2'd0) begin
                    reg_data_in_d = (reg_data_out & ~mask_q) | (val_q & mask_q);
                    phase_d       = 2'd1;
                end else begin
                    reg_io_enable = 2'd2;
                    state_d       = S_DISPATCH;
                end
            end
            S_RREG: begin
                if (phase_q == 2'd0) begin
                    reg_io_enable = 2'd3;
                    phase_d       = 2'd1;
                end else begin
                    reply_d[0]   = 16'h0506;
                    reply_d[1]   = cmd_lo_q;
                    reply_d[2]   = reg_data_out[31:16];
                    reply_d[3]   = reg_data_out[15:0];
                    reply_len_d  = 3'd4;
                    reply_idx_d  = 2'd0;
                    rx_databus_d = 16'h0506;
                    phase_d      = 2'd0;
                    state_d      = S_SEND;
                end
            end
            S_DELAY: begin
                stop_d      = 1'b1;
                stop_time_d = cmd_lo_q;
                state_d     = S_DISPATCH;
            end
            S_SEND: begin
                // rx_databus is preloaded with the pending word, so a stall
                // simply holds it; phase 1 is the rx_WR_done cycle.
                if (phase_q == 2'd1) begin
                    rx_WR_done = 1'b1;
                    state_d    = S_DISPATCH;
                end else if (rx_WR_enabled) begin
                    rx_WR = 1'b1;
                    if ({1'b0, reply_idx_q} == (reply_len_q - 3'd1)) begin
                        phase_d = 2'd1;
                    end else begin
                        reply_idx_d  = reply_idx_q + 2'd1;
                        rx_databus_d = reply_q[reply_idx_q + 2'd1];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_d = err_q;
        if (err_inc && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            phase_q       <= 2'd0;
            remaining_q   <= 7'd0;
            ts_q          <= 32'd0;
            cmd_lo_q      <= 16'd0;
            val_q         <= 32'd0;
            mask_q        <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                reply_q[i] <= 16'd0;
            end
            reply_len_q   <= 3'd0;
            reply_idx_q   <= 2'd0;
            rx_databus_q  <= 16'd0;
            reg_addr_q    <= '0;
            reg_data_in_q <= 32'd0;
            stop_q        <= 1'b0;
            stop_time_q   <= 16'd0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            remaining_q   <= remaining_d;
            ts_q          <= ts_d;
            cmd_lo_q      <= cmd_lo_d;
            val_q         <= val_d;
            mask_q        <= mask_d;
            for (int i = 0; i < 4; i++) begin
                reply_q[i] <= reply_d[i];
            end
            reply_len_q   <= reply_len_d;
            reply_idx_q   <= reply_idx_d;
            rx_databus_q  <= rx_databus_d;
            reg_addr_q    <= reg_addr_d;
            reg_data_in_q <= reg_data_in_d;
            stop_q        <= stop_d;
            stop_time_q   <= stop_time_d;
            err_q         <= err_d;
        end
    end

    assign rx_databus  = rx_databus_q;
    assign reg_addr    = reg_addr_q;
    assign reg_data_in = reg_data_in_q;
    assign stop        = stop_q;
    assign stop_time   = stop_time_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_cmd_reader_rmw.sv
// ---------------------------------------------------------------------------
// tb_cmd_reader_rmw
//   Directed bench for cmd_reader_rmw. It models the show-ahead FIFO, the
//   register file (read data valid the cycle after a read) and the RX path.
//   Packets are pushed and the run continues until the packet's closing
//   skip. Logged bus activity is compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_cmd_reader_rmw;
    localparam int ADDR_W = 7;
    localparam int ERR_W  = 8;

    logic              txclk = 1'b0;
    logic              reset;
    logic [31:0]       timestamp_clock;
    logic              pkt_waiting;
    logic [31:0]       fifodata;
    logic              rdreq;
    logic              skip;
    logic              rx_WR_enabled;
    logic              rx_WR;
    logic [15:0]       rx_databus;
    logic              rx_WR_done;
    logic [31:0]       reg_data_out;
    logic [31:0]       reg_data_in;
    logic [ADDR_W-1:0] reg_addr;
    logic [1:0]        reg_io_enable;
    logic              stop;
    logic [15:0]       stop_time;
    logic [ERR_W-1:0]  err_count;

    always #5 txclk = ~txclk;

    cmd_reader_rmw #(.JITTER(5), .ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
        .txclk(txclk), .reset(reset), .timestamp_clock(timestamp_clock),
        .pkt_waiting(pkt_waiting), .fifodata(fifodata), .rdreq(rdreq), .skip(skip),
        .rx_WR_enabled(rx_WR_enabled), .rx_WR(rx_WR), .rx_databus(rx_databus),
        .rx_WR_done(rx_WR_done), .reg_data_out(reg_data_out), .reg_data_in(reg_data_in),
        .reg_addr(reg_addr), .reg_io_enable(reg_io_enable), .stop(stop),
        .stop_time(stop_time), .err_count(err_count)
    );

    int vectors_applied = 0;
    int miscompares     = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO, register and RX models
    logic [31:0] fifo_q[$];
    int          pkt_len_q[$];
    int          cur_left = 0;
    logic [31:0] regs [128];
    logic        toggle_en = 1'b0;

    logic [15:0] rx_log[$];
    logic [31:0] rx_tsc[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] wr_tsc_log[$];
    int          rd_n, done_n, skip_n, stop_n, io_n;
    logic [31:0] rd_tsc, done_tsc, skip_tsc;
    int          clash_n = 0;
    int          stall_err_n = 0;

    task automatic clear_logs();
        rx_log.delete(); rx_tsc.delete();
        wr_addr_log.delete(); wr_data_log.delete(); wr_tsc_log.delete();
        rd_n = 0; done_n = 0; stop_n = 0; io_n = 0;
        rd_tsc = 0; done_tsc = 0; skip_tsc = 0;
    endtask

    task automatic tick();
        logic              do_pop;
        logic              do_skip;
        logic              do_rd;
        logic [ADDR_W-1:0] rd_a;
        @(negedge txclk);
        do_pop  = rdreq;
        do_skip = skip;
        do_rd   = 1'b0;
        rd_a    = reg_addr;
        if (rdreq && skip) clash_n++;
        if (rx_WR) begin
            rx_log.push_back(rx_databus);
            rx_tsc.push_back(timestamp_clock);
            if (!rx_WR_enabled) stall_err_n++;
        end
        if (rx_WR_done) begin done_n++; done_tsc = timestamp_clock; end
        if (skip) begin skip_n++; skip_tsc = timestamp_clock; end
        if (stop) stop_n++;
        if (reg_io_enable != 2'd0) io_n++;
        if (reg_io_enable == 2'd2) begin
            wr_addr_log.push_back(32'(reg_addr));
            wr_data_log.push_back(reg_data_in);
            wr_tsc_log.push_back(timestamp_clock);
            regs[reg_addr] = reg_data_in;
        end
        if (reg_io_enable == 2'd3) begin
            rd_n++;
            rd_tsc = timestamp_clock;
            do_rd  = 1'b1;
        end
        @(posedge txclk);
        #1;
        if (do_pop) begin
            if (cur_left == 0 && pkt_len_q.size() > 0) cur_left = pkt_len_q.pop_front();
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (cur_left > 0) cur_left--;
        end
        if (do_skip) begin
            while (cur_left > 0 && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                cur_left--;
            end
            cur_left = 0;
        end
        fifodata        = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
        pkt_waiting     = (pkt_len_q.size() > 0);
        reg_data_out    = do_rd ? regs[rd_a] : 32'hA5A5_A5A5;
        timestamp_clock = timestamp_clock + 32'd1;
        rx_WR_enabled   = toggle_en ? ~rx_WR_enabled : 1'b1;
    endtask

    task automatic push_pkt(input logic [31:0] ts, input int n,
                            input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
        logic [31:0] cmds [3];
        cmds[0] = c0; cmds[1] = c1; cmds[2] = c2;
        fifo_q.push_back(32'(n) << 2);
        fifo_q.push_back(ts);
        for (int i = 0; i < n; i++) fifo_q.push_back(cmds[i]);
        pkt_len_q.push_back(n + 2);
        fifodata    = fifo_q[0];
        pkt_waiting = 1'b1;
    endtask

    // Every packet ends with exactly one skip (normal end or drop).
    task automatic run_pkt(input string tag);
        int start;
        int budget;
        start  = skip_n;
        budget = 0;
        while (skip_n == start && budget < 300) begin
            tick();
            budget++;
        end
        check_eq({tag, "_skip"}, 64'(skip_n - start), 64'd1);
        repeat (3) tick();
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx_log.size()) ? {16'd0, rx_log[i]} : 32'hFFFF_FFFF;
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) regs[i] = 32'd0;
        reset           = 1'b1;
        timestamp_clock = 32'd1000;
        pkt_waiting     = 1'b0;
        fifodata        = 32'd0;
        rx_WR_enabled   = 1'b1;
        reg_data_out    = 32'hA5A5_A5A5;
        skip_n          = 0;
        clear_logs();

        repeat (3) tick();
        check_eq("reset_ctrl", {rdreq, skip, rx_WR, rx_WR_done, reg_io_enable, stop, rx_databus, stop_time},
                 64'd0);
        check_eq("reset_data", {reg_data_in, 1'b0, reg_addr, err_count}, 64'd0);
        reset = 1'b0;
        tick();

        // T1 PING, immediate timestamp
        clear_logs();
        push_pkt(32'hFFFF_FFFF, 1, 32'h0000_ABCD, 32'd0, 32'd0);
        run_pkt("t1");
        check_eq("t1_nwords", 64'(rx_log.size()), 64'd2);
        check_eq("t1_w0", rx_at(0), 64'h0102);
        check_eq("t1_w1", rx_at(1), 64'hABCD);
        check_eq("t1_done_n", 64'(done_n), 64'd1);
        check_eq("t1_done_at", done_tsc, (rx_tsc.size() > 1) ? rx_tsc[1] + 32'd1 : 32'd0);
        check_eq("t1_skip_at", skip_tsc, done_tsc + 32'd1);
        $display("t1 ping: %0d words, err=%0d", rx_log.size(), err_count);

        // T2 masked RMW
        clear_logs();
        regs[5] = 32'hFFFF_0000;
        push_pkt(32'hFFFF_FFFF, 3, 32'h0300_0005, 32'h0000_1234, 32'h00FF_00FF);
        run_pkt("t2");
        check_eq("t2_nwr", 64'(wr_data_log.size()), 64'd1);
        check_eq("t2_addr", (wr_addr_log.size() > 0) ? wr_addr_log[0] : 32'hFFFF_FFFF, 64'd5);
        check_eq("t2_data", (wr_data_log.size() > 0) ? wr_data_log[0] : 32'd0, 64'hFF00_0034);
        check_eq("t2_nrd", 64'(rd_n), 64'd1);
        check_eq("t2_lat", (wr_tsc_log.size() > 0) ? wr_tsc_log[0] - rd_tsc : 32'd0, 64'd2);
        $display("t2 rmw: reg5=0x%08h", regs[5]);

        // T3 future timestamp executes at first in-window cycle; stale drops
        clear_logs();
        begin
            logic [31:0] ts;
            ts = timestamp_clock + 32'd40;
            push_pkt(ts, 2, 32'h0200_0011, 32'h1357_9BDF, 32'd0);
            run_pkt("t3a");
            check_eq("t3a_data", (wr_data_log.size() > 0) ? wr_data_log[0] : 32'd0, 64'h1357_9BDF);
            check_eq("t3a_when", (wr_tsc_log.size() > 0) ? wr_tsc_log[0] : 32'd0, ts - 32'd2);
        end
        $display("t3a wait: write at tsc=%0d", (wr_tsc_log.size() > 0) ? wr_tsc_log[0] : 0);
        clear_logs();
        push_pkt(timestamp_clock - 32'd1, 2, 32'h0200_0012, 32'h0000_0001, 32'd0);
        run_pkt("t3b");
        check_eq("t3b_err", 64'(err_count), 64'd1);
        check_eq("t3b_io", 64'(io_n), 64'd0);
        $display("t3b stale: err=%0d", err_count);

        // T4 wait across the 2^32 wrap
        clear_logs();
        timestamp_clock = 32'hFFFF_FFF0;
        push_pkt(32'h0000_0002, 2, 32'h0200_0022, 32'hCAFE_F00D, 32'd0);
        run_pkt("t4");
        check_eq("t4_data", (wr_data_log.size() > 0) ? wr_data_log[0] : 32'd0, 64'hCAFE_F00D);
        check_eq("t4_when", (wr_tsc_log.size() > 0) ? wr_tsc_log[0] : 32'hFFFF_FFFF, 64'd0);
        check_eq("t4_err", 64'(err_count), 64'd1);
        $display("t4 wrap: nwr=%0d err=%0d", wr_data_log.size(), err_count);

        // T5 READ_REG with a stalling RX path
        clear_logs();
        regs[9]   = 32'hDEAD_BEEF;
        toggle_en = 1'b1;
        push_pkt(32'hFFFF_FFFF, 1, 32'h0400_0009, 32'd0, 32'd0);
        run_pkt("t5");
        toggle_en = 1'b0;
        check_eq("t5_nwords", 64'(rx_log.size()), 64'd4);
        check_eq("t5_w0", rx_at(0), 64'h0506);
        check_eq("t5_w1", rx_at(1), 64'h0009);
        check_eq("t5_w2", rx_at(2), 64'hDEAD);
        check_eq("t5_w3", rx_at(3), 64'hBEEF);
        check_eq("t5_done_n", 64'(done_n), 64'd1);
        $display("t5 read: %0d words", rx_log.size());

        // T6 truncated WRITE_REG and unknown opcode
        clear_logs();
        push_pkt(32'hFFFF_FFFF, 1, 32'h0200_0003, 32'd0, 32'd0);
        run_pkt("t6a");
        check_eq("t6a_err", 64'(err_count), 64'd2);
        check_eq("t6a_io", 64'(io_n), 64'd0);
        clear_logs();
        push_pkt(32'hFFFF_FFFF, 1, 32'h7F00_0000, 32'd0, 32'd0);
        run_pkt("t6b");
        check_eq("t6b_err", 64'(err_count), 64'd3);
        check_eq("t6b_io", 64'(io_n), 64'd0);
        $display("t6 drops: err=%0d", err_count);

        // T7 DELAY followed by WRITE_REG in one packet
        clear_logs();
        push_pkt(32'hFFFF_FFFF, 3, 32'h0C00_0456, 32'h0200_0030, 32'h0000_00AA);
        run_pkt("t7");
        check_eq("t7_stop_n", 64'(stop_n), 64'd1);
        check_eq("t7_stop_time", 64'(stop_time), 64'h0456);
        check_eq("t7_addr", (wr_addr_log.size() > 0) ? wr_addr_log[0] : 32'hFFFF_FFFF, 64'h30);
        check_eq("t7_data", (wr_data_log.size() > 0) ? wr_data_log[0] : 32'd0, 64'hAA);
        $display("t7 delay: stop_time=0x%04h", stop_time);

        // T8 err_count saturation: 252 more drops reach 255, one more stays
        for (int k = 0; k < 252; k++) begin
            push_pkt(timestamp_clock - 32'd1, 1, 32'h0000_0001, 32'd0, 32'd0);
            run_pkt("t8_fill");
        end
        check_eq("t8_full", 64'(err_count), 64'd255);
        push_pkt(timestamp_clock - 32'd1, 1, 32'h0000_0001, 32'd0, 32'd0);
        run_pkt("t8_sat");
        check_eq("t8_sat", 64'(err_count), 64'd255);
        $display("t8 saturate: err=%0d", err_count);

        check_eq("skip_with_rdreq", 64'(clash_n), 64'd0);
        check_eq("rx_wr_while_stalled", 64'(stall_err_n), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
